// File: rtl/tdm_demux16.sv
// tdm_demux16: receive side of the mux16 serial link.
// Owns the slot counter (driven out on sel to steer the upstream mux16),
// rebuilds the 1-bit-per-cycle stream into an N_CH-bit word and presents it
// on a valid/ready output.
// Optional feature macro: PARITY_CHECK_EN adds one even-parity slot per
// frame (slot N_CH), widens sel by one bit and enables parity_err.
//
// Output handshake: a word is transferred on a cycle where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, out and
// out_valid hold. A frame completing while a word is still pending replaces
// it and raises overrun for one cycle; completing on the accept cycle itself
// is a clean hand-over (no overrun).
module tdm_demux16 #(
    parameter int N_CH  = 16,
    parameter int SEL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              q,
    input  logic              q_valid,
    input  logic              sof,
`ifdef PARITY_CHECK_EN
    output logic [SEL_W:0]    sel,
`else
    output logic [SEL_W-1:0]  sel,
`endif
    output logic [N_CH-1:0]   out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int SW   = SEL_W + 1;
    localparam int LAST = N_CH;
`else
    localparam int SW   = SEL_W;
    localparam int LAST = N_CH - 1;
`endif

    localparam logic [SW-1:0] LAST_SEL = SW'(LAST);
    localparam logic [SW-1:0] ONE_SEL  = SW'(1);

    logic [N_CH-1:0]  shadow;
    logic [N_CH-1:0]  shadow_upd;
    logic [SEL_W-1:0] idx;
    logic             last_slot;
    logic             complete;

    assign idx       = sel[SEL_W-1:0];
    assign last_slot = (sel == LAST_SEL);
    assign complete  = q_valid && !sof && last_slot;

    // Shadow word with the current bit merged in at the current slot.
    always_comb begin
        shadow_upd      = shadow;
        shadow_upd[idx] = q;
    end

    // Slot counter, shadow capture and output word/handshake registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel       <= '0;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            // sof realigns the counter; with a live bit that bit is slot 0.
            if (sof) begin
                if (q_valid) begin
                    shadow[0] <= q;
                    sel       <= ONE_SEL;
                end else begin
                    sel <= '0;
                end
            end else if (q_valid) begin
                if (last_slot) sel <= '0;
                else           sel <= sel + ONE_SEL;
`ifdef PARITY_CHECK_EN
                // The parity slot is checked, never stored.
                if (!last_slot) shadow <= shadow_upd;
`else
                shadow <= shadow_upd;
`endif
            end

            if (complete) begin
`ifdef PARITY_CHECK_EN
                out        <= shadow;
                parity_err <= ^{shadow, q};
`else
                out        <= shadow_upd;
`endif
                out_valid  <= 1'b1;
                overrun    <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed testbench for tdm_demux16 (default build or PARITY_CHECK_EN).
module tb_tdm_demux16;

`ifdef PARITY_CHECK_EN
    localparam int FRAME_LEN = 17;
    logic [4:0] sel;
`else
    localparam int FRAME_LEN = 16;
    logic [3:0] sel;
`endif
    localparam int LAST = FRAME_LEN - 1;

    logic        clk;
    logic        rst_n;
    logic        q;
    logic        q_valid;
    logic        sof;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        parity_err;

    int n_checks;
    int n_fail;
    int overrun_cnt;
    int rise_cnt;
    int perr_cnt;
    logic prev_valid;
    logic par_flip;

    tdm_demux16 #(.N_CH(16), .SEL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q          (q),
        .q_valid    (q_valid),
        .sof        (sof),
        .sel        (sel),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pulse / edge monitor, sampled mid-cycle
    initial begin
        overrun_cnt = 0;
        rise_cnt    = 0;
        perr_cnt    = 0;
        prev_valid  = 1'b0;
        forever begin
            @(negedge clk);
            if (overrun)                  overrun_cnt = overrun_cnt + 1;
            if (parity_err)               perr_cnt    = perr_cnt + 1;
            if (out_valid && !prev_valid) rise_cnt    = rise_cnt + 1;
            prev_valid = out_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock with the given inputs; returns 1 time unit after the edge
    task automatic cycle(input logic v, input logic b, input logic s);
        q_valid = v;
        q       = b;
        sof     = s;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        sof     = 1'b0;
    endtask

    function automatic logic fbit(input logic [15:0] w, input int i);
        if (i < 16) return w[i];
        return (^w) ^ par_flip;
    endfunction

    // send frame slots lo..hi of word w; sof on slot 0 when use_sof
    task automatic send_slots(input logic [15:0] w, input int lo, input int hi, input logic use_sof);
        for (int i = lo; i <= hi; i++)
            cycle(1'b1, fbit(w, i), use_sof && (i == 0));
    endtask

    int base_ov;
    int base_rise;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        par_flip  = 1'b0;
        rst_n     = 1'b0;
        q         = 1'b0;
        q_valid   = 1'b0;
        sof       = 1'b0;
        out_ready = 1'b1;

        // reset
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // 1 walking one, sel sequence 0..LAST then 0
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk($sformatf("t1_sel%0d", i), 32'(sel), 32'(i));
            if (i == LAST) chk("t1_valid_before_last", 32'(out_valid), 32'd0);
            cycle(1'b1, fbit(16'h0020, i), i == 0);
        end
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_out", 32'(out), 32'h0020);
        chk("t1_sel_wrap", 32'(sel), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t1_accept", 32'(out_valid), 32'd0);

        // 2 walking zero with a 3-cycle bubble after slot 7
        send_slots(16'h7FFF, 0, 7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("t2_bubble_sel", 32'(sel), 32'd8);
            chk("t2_bubble_valid", 32'(out_valid), 32'd0);
        end
        send_slots(16'h7FFF, 8, LAST, 1'b0);
        chk("t2_out", 32'(out), 32'h7FFF);
        chk("t2_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);

        // 3 backpressure and overrun
        out_ready = 1'b0;
        base_ov   = overrun_cnt;
        send_slots(16'hA5A5, 0, LAST, 1'b1);
        chk("t3_first_out", 32'(out), 32'hA5A5);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t3_hold_valid", 32'(out_valid), 32'd1);
        chk("t3_hold_out", 32'(out), 32'hA5A5);
        send_slots(16'h0F0F, 0, LAST, 1'b1);
        chk("t3_overrun_pulse", 32'(overrun), 32'd1);
        chk("t3_out", 32'(out), 32'h0F0F);
        chk("t3_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t3_overrun_clear", 32'(overrun), 32'd0);
        chk("t3_overrun_count", 32'(overrun_cnt - base_ov), 32'd1);
        out_ready = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        chk("t3_accept_valid", 32'(out_valid), 32'd0);
        chk("t3_accept_out", 32'(out), 32'h0F0F);

        // 3b completion on the accept cycle: clean hand-over
        out_ready = 1'b0;
        base_ov   = overrun_cnt;
        send_slots(16'h5555, 0, LAST, 1'b1);
        send_slots(16'h3333, 0, LAST - 1, 1'b1);
        out_ready = 1'b1;
        send_slots(16'h3333, LAST, LAST, 1'b0);
        chk("t3b_out", 32'(out), 32'h3333);
        chk("t3b_valid", 32'(out_valid), 32'd1);
        chk("t3b_no_overrun", 32'(overrun_cnt - base_ov), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t3b_accept", 32'(out_valid), 32'd0);

        // 4 resync at slot 9
        base_rise = rise_cnt;
        send_slots(16'hFFFF, 0, 8, 1'b1);
        chk("t4_sel9", 32'(sel), 32'd9);
        send_slots(16'h1234, 0, LAST, 1'b1);
        chk("t4_out", 32'(out), 32'h1234);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t4_one_valid", 32'(rise_cnt - base_rise), 32'd1);

        // 5 reset at slot 7
        send_slots(16'hAAAA, 0, 6, 1'b1);
        chk("t5_sel7", 32'(sel), 32'd7);
        rst_n = 1'b0;
        cycle(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        chk("t5_sel", 32'(sel), 32'd0);
        chk("t5_out", 32'(out), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        send_slots(16'hFFFF, 0, LAST, 1'b0);
        chk("t5_frame_out", 32'(out), 32'hFFFF);
        chk("t5_frame_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);

`ifdef PARITY_CHECK_EN
        // 6 parity: good then bad
        par_flip = 1'b0;
        send_slots(16'h0001, 0, LAST, 1'b1);
        chk("t6_good_perr", 32'(parity_err), 32'd0);
        chk("t6_good_out", 32'(out), 32'h0001);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t6_good_accept", 32'(out_valid), 32'd0);
        par_flip = 1'b1;
        send_slots(16'h0001, 0, LAST, 1'b1);
        chk("t6_bad_perr", 32'(parity_err), 32'd1);
        chk("t6_bad_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t6_perr_clear", 32'(parity_err), 32'd0);
        chk("t6_perr_count", 32'(perr_cnt), 32'd1);
        par_flip = 1'b0;
`else
        chk("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
